// File: rtl/crc24_pkg.sv
// crc24_pkg: shared types and constants for the BLE CRC-24 receive checker.
// The LFSR is kept in byte-reversed order relative to crc_state_init.
package crc24_pkg;

  localparam int CRC_W = 24;
  localparam logic [CRC_W-1:0] ADV_CRC_INIT = 24'h555555;
  localparam logic [CRC_W-1:0] CRC_POLY = 24'h00065B;

  typedef enum logic [1:0] {
    IDLE,
    PDU,
    CRC
  } state_t;

  function automatic logic [CRC_W-1:0] byte_order(
    input logic [CRC_W-1:0] v
  );
    return {v[7:0], v[15:8], v[23:16]};
  endfunction

endpackage

// File: rtl/crc24_core.sv
// crc24_core: bit-serial CRC-24 LFSR, x^24+x^10+x^9+x^6+x^4+x^3+x+1.
// Init is byte-reordered on load; the LFSR holds whenever din_valid is low.
module crc24_core
  import crc24_pkg::*;
#(
  parameter int CRC_STATE_BIT_WIDTH = CRC_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init,
  input  logic                           load,
  input  logic                           din,
  input  logic                           din_valid,
  output logic [CRC_STATE_BIT_WIDTH-1:0] lfsr
);

  logic fb;

  assign fb = lfsr[CRC_STATE_BIT_WIDTH-1] ^ din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= byte_order(crc_state_init);
    end else if (load) begin
      lfsr <= byte_order(crc_state_init);
    end else if (din_valid) begin
      lfsr <= {lfsr[CRC_STATE_BIT_WIDTH-2:0], 1'b0}
            ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/crc24_check.sv
// crc24_check: RX-side BLE CRC-24 checker; runs the PDU through crc24_core,
// then collects the 24 received CRC bits and reports a per-packet verdict.
module crc24_check
  import crc24_pkg::*;
#(
  parameter int LEN_WIDTH           = 8,
  parameter int CRC_STATE_BIT_WIDTH = CRC_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           pdu_len_byte,
  input  logic                           data_in,
  input  logic                           data_in_valid,
  output logic                           busy,
  output logic [CRC_STATE_BIT_WIDTH-1:0] crc_calc,
  output logic [CRC_STATE_BIT_WIDTH-1:0] crc_rx,
  output logic                           crc_done,
  output logic                           crc_ok
);

  localparam int CW = LEN_WIDTH + 3;

  state_t                         state, state_d;
  logic [CW-1:0]                  cnt;
  logic [CW-1:0]                  len_bits;
  logic                           cap_pend;
  logic                           len_zero;
  logic                           last_pdu;
  logic                           last_crc;
  logic                           core_valid;
  logic [CRC_STATE_BIT_WIDTH-1:0] core_lfsr;
  logic [CRC_STATE_BIT_WIDTH-1:0] rx_next;

  assign len_zero   = (pdu_len_byte == '0);
  assign last_pdu   = (cnt == len_bits - CW'(1));
  assign last_crc   = (cnt == CW'(CRC_STATE_BIT_WIDTH - 1));
  assign rx_next    = {crc_rx[CRC_STATE_BIT_WIDTH-2:0], data_in};
  assign busy       = (state != IDLE);
  assign core_valid = (state == PDU) && data_in_valid && !start;

  crc24_core #(
    .CRC_STATE_BIT_WIDTH(CRC_STATE_BIT_WIDTH)
  ) u_core (
    .clk           (clk),
    .rst           (rst),
    .crc_state_init(crc_state_init),
    .load          (start),
    .din           (data_in),
    .din_valid     (core_valid),
    .lfsr          (core_lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (start) begin
      state_d = len_zero ? CRC : PDU;
    end else begin
      unique case (state)
        IDLE: state_d = IDLE;
        PDU:  if (data_in_valid && last_pdu) state_d = CRC;
        CRC:  if (data_in_valid && last_crc) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // cap_pend is high only on the first CRC-state cycle, once the core
  // has absorbed the final PDU bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      len_bits <= '0;
      cap_pend <= 1'b0;
      crc_calc <= '0;
      crc_rx   <= '0;
      crc_done <= 1'b0;
      crc_ok   <= 1'b0;
    end else begin
      crc_done <= 1'b0;
      cap_pend <= 1'b0;
      if (cap_pend) crc_calc <= core_lfsr;
      if (start) begin
        len_bits <= {pdu_len_byte, 3'b000};
        cnt      <= '0;
        crc_ok   <= 1'b0;
        crc_rx   <= '0;
        cap_pend <= len_zero;
      end else if (data_in_valid) begin
        unique case (state)
          IDLE: cnt <= cnt;
          PDU: begin
            cnt      <= last_pdu ? '0 : cnt + CW'(1);
            cap_pend <= last_pdu;
          end
          CRC: begin
            crc_rx <= rx_next;
            cnt    <= last_crc ? '0 : cnt + CW'(1);
            if (last_crc) begin
              crc_done <= 1'b1;
              crc_ok   <= (rx_next == crc_calc);
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crc24_check.sv
// tb_crc24_check: randomized scoreboard bench for crc24_check.
// Expected CRCs come from polynomial long division over a bit queue.
module tb_crc24_check;
  import crc24_pkg::*;

  typedef struct {
    logic [23:0] calc;
    logic [23:0] rx;
    logic        ok;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] crc_state_init;
  logic        start;
  logic [7:0]  pdu_len_byte;
  logic        data_in;
  logic        data_in_valid;
  logic        busy;
  logic [23:0] crc_calc;
  logic [23:0] crc_rx;
  logic        crc_done;
  logic        crc_ok;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   dones = 0;
  int   exp_dones = 0;
  bit   in_pkt = 1'b0;

  always #5 clk = ~clk;

  crc24_check #(
    .LEN_WIDTH(8),
    .CRC_STATE_BIT_WIDTH(24)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .crc_state_init(crc_state_init),
    .start         (start),
    .pdu_len_byte  (pdu_len_byte),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .busy          (busy),
    .crc_calc      (crc_calc),
    .crc_rx        (crc_rx),
    .crc_done      (crc_done),
    .crc_ok        (crc_ok)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Remainder of (S*x^n + M(x)*x^24) mod P, by long division.
  function automatic logic [23:0] crc_model(input logic [23:0] init,
                                            input bit bits[$]);
    bit          arr[$];
    logic [24:0] p;
    logic [23:0] s;
    logic [23:0] r;
    int          n;
    p = {1'b1, CRC_POLY};
    s = {init[7:0], init[15:8], init[23:16]};
    n = bits.size();
    arr = bits;
    for (int k = 0; k < 24; k++) arr.push_back(1'b0);
    for (int k = 0; k < 24; k++) arr[k] = arr[k] ^ s[23-k];
    for (int i = 0; i < n; i++)
      if (arr[i])
        for (int j = 0; j < 25; j++) arr[i+j] = arr[i+j] ^ p[24-j];
    for (int k = 0; k < 24; k++) r[23-k] = arr[n+k];
    return r;
  endfunction

  always @(negedge clk) begin
    if (in_pkt) chk("busy_in_pkt", 32'(busy), 32'd1);
    if (crc_done) begin
      dones++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(crc_done), 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("crc_calc", 32'(crc_calc), 32'(mon_e.calc));
        chk("crc_rx", 32'(crc_rx), 32'(mon_e.rx));
        chk("crc_ok", 32'(crc_ok), 32'(mon_e.ok));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [23:0] init, input int len,
                          input bit with_bit);
    crc_state_init = init;
    pdu_len_byte   = 8'(len);
    start          = 1'b1;
    data_in_valid  = with_bit;
    data_in        = 1'($urandom % 2);
    tick();
    start         = 1'b0;
    data_in_valid = 1'b0;
  endtask

  task automatic send_bit(input bit b, input bit gaps);
    if (gaps) while ($urandom % 2) tick();
    data_in       = b;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    data_in       = 1'($urandom % 2);
  endtask

  task automatic send_pkt(input logic [23:0] init, input int len,
                          input logic [23:0] flip, input bit gaps,
                          input bit with_bit);
    bit          bits[$];
    logic [23:0] calc;
    logic [23:0] rx;
    for (int i = 0; i < len * 8; i++) bits.push_back(1'($urandom % 2));
    calc = crc_model(init, bits);
    rx   = calc ^ flip;
    q.push_back('{calc: calc, rx: rx, ok: (rx == calc)});
    exp_dones++;
    do_start(init, len, with_bit);
    in_pkt = 1'b1;
    foreach (bits[i]) send_bit(bits[i], gaps);
    for (int k = 23; k >= 0; k--) send_bit(rx[k], gaps);
    in_pkt = 1'b0;
    @(negedge clk);
    chk("done_latency", 32'(crc_done), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    crc_state_init = ADV_CRC_INIT;
    start          = 1'b0;
    pdu_len_byte   = '0;
    data_in        = 1'b0;
    data_in_valid  = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(crc_done), 32'd0);
    chk("rst_ok", 32'(crc_ok), 32'd0);
    chk("rst_rx", 32'(crc_rx), 32'd0);
    chk("rst_calc", 32'(crc_calc), 32'd0);
    tick();
    rst = 1'b0;
    // data_in_valid in IDLE must be ignored
    repeat (5) send_bit(1'b1, 1'b0);
    chk("idle_busy", 32'(busy), 32'd0);

    send_pkt(ADV_CRC_INIT, 0, 24'h0, 1'b0, 1'b0);
    chk("len0_calc", 32'(crc_calc), 32'h555555);
    chk("len0_rx", 32'(crc_rx), 32'h555555);
    repeat (4) tick();
    @(negedge clk);
    chk("ok_held", 32'(crc_ok), 32'd1);

    send_pkt(ADV_CRC_INIT, 0, 24'h000020, 1'b0, 1'b0);
    chk("flip_rx", 32'(crc_rx), 32'h555575);
    chk("flip_ok", 32'(crc_ok), 32'd0);

    send_pkt(ADV_CRC_INIT, 6, 24'h0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      send_pkt(24'($urandom), int'($urandom_range(9, 0)),
               (i % 3 == 2) ? 24'(1 << $urandom_range(23, 0)) : 24'h0,
               1'b1, 1'b0);

    send_pkt(24'($urandom), 255, 24'h0, 1'b0, 1'b0);

    do_start(ADV_CRC_INIT, 37, 1'b0);
    in_pkt = 1'b1;
    for (int i = 0; i < 100; i++) send_bit(1'($urandom % 2), 1'b1);
    in_pkt = 1'b0;
    send_pkt(24'($urandom), 2, 24'h0, 1'b1, 1'b0);

    do_start(ADV_CRC_INIT, 3, 1'b0);
    for (int i = 0; i < 34; i++) send_bit(1'($urandom % 2), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ok", 32'(crc_ok), 32'd0);
    chk("midrst_rx", 32'(crc_rx), 32'd0);
    tick();
    rst = 1'b0;
    repeat (30) tick();
    send_pkt(ADV_CRC_INIT, 4, 24'h0, 1'b1, 1'b0);

    send_pkt(24'($urandom), 5, 24'h0, 1'b1, 1'b1);

    repeat (5) tick();
    chk("done_count", 32'(dones), 32'(exp_dones));
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
